mux_sel_ctrl: RTL and testbench
===============================

// Module: mux_sel_ctrl
// PURPOSE
//   Generates the 2-bit select that drives the board's 4:1 2-bit mux (select input y).
//   Two raw push-buttons step the select forward or back, and a switch enables auto-scan.
//   Buttons are synchronized and debounced; auto-scan steps the select on a fixed period.
//   sel connects directly to the mux select; sel_chg and mode go to LEDs/debug.
// PARAMETERS
//   SEL_W            2   select width; select wraps modulo 2**SEL_W
//   DEBOUNCE_CYCLES  4   consecutive stable cycles needed to accept a button level (>=1; 1_000_000 on board)
//   AUTO_PERIOD      8   cycles between auto-scan steps (>=2)
// PORTS
//   clk       in   1      single clock; all state on posedge
//   rst       in   1      synchronous, active-high reset
//   btn_next  in   1      raw button, active-high, asynchronous, bouncy
//   btn_prev  in   1      raw button, active-high, asynchronous, bouncy
//   auto_en   in   1      raw switch, 1 = auto-scan mode
//   sel       out  SEL_W  mux select, registered
//   sel_chg   out  1      one-cycle pulse, registered; high in the cycle after sel takes a new value
//   mode      out  1      0 = MANUAL, 1 = AUTO (registered FSM state)
// BEHAVIOUR
//   Reset (rst=1 at posedge)
//     - sel=0, sel_chg=0, mode=MANUAL.
//     - All sync flops, debounced levels, debounce counters and period counter are cleared to 0.
//     - Reset mid-operation aborts any pending debounce or auto step; nothing carries over.
//   Synchronizer
//     - 2-FF synchronizer on each of btn_next, btn_prev and auto_en.
//     - Let E be the edge at which FF1 first captures 1; FF2 (sync level) is 1 after edge E+1.
//   Debounce (per button)
//     - Stable level db and counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
//     - At each edge where sync != db: cnt++.
//     - When cnt reaches DEBOUNCE_CYCLES, db flips at that edge and cnt clears to 0.
//     - At any edge where sync == db: cnt clears to 0, so a bounce restarts the count.
//     - A press is db rising, i.e. db_next & ~db, evaluated combinationally.
//     - Release (db falling) has no effect on sel.
//   FSM states: MANUAL, AUTO
//     - MANUAL -> AUTO at the first edge where sync(auto_en)=1; period counter loads 0.
//     - AUTO -> MANUAL at the first edge where sync(auto_en)=0; period counter loads 0.
//   MANUAL select update, applied at the same edge as the db flip
//     - press_next only: sel = sel+1; wraps 3 -> 0.
//     - press_prev only: sel = sel-1; wraps 0 -> 3.
//     - Both presses at the same edge: sel unchanged, no sel_chg.
//     - Latency: sel changes at edge E+1+DEBOUNCE_CYCLES (E+5 with the default).
//   AUTO
//     - Period counter pc counts 0..AUTO_PERIOD-1.
//     - At the edge where pc==AUTO_PERIOD-1: sel = sel+1 with wrap, and pc loads 0.
//     - First step occurs AUTO_PERIOD edges after the AUTO entry edge.
//     - Button presses are ignored in AUTO, but debounce keeps tracking the button levels.
//       Leaving AUTO while a button is held therefore does not produce a press.
//   sel_chg
//     - Asserted for exactly the cycle following any edge at which sel changed, otherwise 0.
//     - No pulse on reset, on a mode change alone, or on simultaneous presses.
//   All arithmetic is SEL_W-bit unsigned modulo; there is no saturation.
// TESTING
//   1. rst for 2 cycles, all inputs 0 -> sel=0, sel_chg=0, mode=0; hold 20 cycles, nothing changes.
//   2. btn_next held 1 from edge E -> sel 0->1 at edge E+5, sel_chg=1 for exactly one cycle;
//      4 more clean presses -> sel 2,3,0,1 (wrap).
//   3. btn_next bounce pattern 1,1,0,1,1,1,0 (one level per cycle), then held 1 -> no change during
//      the bounce; sel changes only after 4 consecutive synced 1s.
//   4. btn_next and btn_prev rising in the same cycle, held -> sel unchanged, no sel_chg;
//      btn_prev alone from sel=0 -> sel=3.
//   5. auto_en=1 -> mode=1 two edges later; sel increments every 8 cycles (0,1,2,3,0);
//      presses during AUTO ignored; auto_en=0 -> mode=0, sel holds its last value.
//   6. rst pulsed mid-debounce (cnt=3) and mid-AUTO (pc=5) -> all outputs return to reset values
//      next cycle; with the button still held, a fresh 2+4-cycle latency applies before sel changes.

Source files
------------

// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: produces the select for the board's 4:1 mux.
// Two bouncy push-buttons step the select forward or back. A switch enables
// auto-scan, which steps the select forward on a fixed period. All raw inputs
// are synchronized, and the buttons are debounced before they are used.
module mux_sel_ctrl #(
    parameter int SEL_W           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    output logic [SEL_W-1:0] sel,
    output logic             sel_chg,
    output logic             mode
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PC_W  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    // A button level is accepted on the edge where the counter would reach
    // DEBOUNCE_CYCLES, so the comparison is against one less than that.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(AUTO_PERIOD - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // Bit 0 = btn_next, bit 1 = btn_prev, bit 2 = auto_en.
    logic [2:0] raw;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;
    logic [1:0] press;

    assign raw = {auto_en, btn_prev, btn_next};

    // Two-flop synchronizer on every asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // One debouncer per button. Index 0 is next, and index 1 is prev.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_db
            logic             db_reg;
            logic             db_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // Count consecutive disagreeing samples. Any agreeing sample restarts the count.
            always_comb begin
                db_next  = db_reg;
                cnt_next = '0;
                if (sync2_reg[gi] != db_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        db_next = ~db_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            // Register the stable level and the run counter.
            always_ff @(posedge clk) begin
                if (rst) begin
                    db_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    db_reg  <= db_next;
                    cnt_reg <= cnt_next;
                end
            end

            // A press is the rising edge of the debounced level, seen on the flip edge itself.
            assign press[gi] = db_next & ~db_reg;
        end
    endgenerate

    state_t            state_reg;
    state_t            state_next;
    logic [SEL_W-1:0]  sel_reg;
    logic [SEL_W-1:0]  sel_next;
    logic [PC_W-1:0]   pc_reg;
    logic [PC_W-1:0]   pc_next;
    logic              sel_chg_reg;

    // Mode FSM and select update. Presses only matter in MANUAL mode.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        pc_next    = pc_reg;
        case (state_reg)
            MANUAL: begin
                pc_next = '0;
                if (press[0] && !press[1]) begin
                    sel_next = sel_reg + 1'b1;
                end else if (press[1] && !press[0]) begin
                    sel_next = sel_reg - 1'b1;
                end
                if (sync2_reg[2]) begin
                    state_next = AUTO;
                end
            end
            AUTO: begin
                if (!sync2_reg[2]) begin
                    state_next = MANUAL;
                    pc_next    = '0;
                end else if (pc_reg == PC_LAST) begin
                    sel_next = sel_reg + 1'b1;
                    pc_next  = '0;
                end else begin
                    pc_next = pc_reg + 1'b1;
                end
            end
            default: begin
                state_next = MANUAL;
                pc_next    = '0;
            end
        endcase
    end

    // State, select and period registers. sel_chg flags the edge where sel moved.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= MANUAL;
            sel_reg     <= '0;
            pc_reg      <= '0;
            sel_chg_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            pc_reg      <= pc_next;
            sel_chg_reg <= (sel_next != sel_reg);
        end
    end

    assign sel     = sel_reg;
    assign sel_chg = sel_chg_reg;
    assign mode    = (state_reg == AUTO);

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl. A behavioural model predicts
// sel / sel_chg / mode after every clock edge.
module tb_mux_sel_ctrl;

    localparam int D = 4;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] sel;
    logic       sel_chg;
    logic       mode;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .SEL_W(2),
        .DEBOUNCE_CYCLES(D),
        .AUTO_PERIOD(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .auto_en(auto_en),
        .sel(sel),
        .sel_chg(sel_chg),
        .mode(mode)
    );

    // Model state. Raw samples are delayed by two edges to give the synchronized level.
    // A button level flips once its last D synchronized samples all disagree with it.
    bit [2:0] rawq[$];
    bit       histn[$];
    bit       histp[$];
    bit [1:0] dbv;
    int       m_sel, m_chg, m_mode, since_entry;

    task automatic db_step(input int b, input bit sv, output bit pr);
        bit flip;
        pr = 1'b0;
        if (b == 0) begin
            histn.push_back(sv);
            if (histn.size() > D) void'(histn.pop_front());
            flip = (histn.size() == D);
            foreach (histn[i]) if (histn[i] == dbv[0]) flip = 1'b0;
        end else begin
            histp.push_back(sv);
            if (histp.size() > D) void'(histp.pop_front());
            flip = (histp.size() == D);
            foreach (histp[i]) if (histp[i] == dbv[1]) flip = 1'b0;
        end
        if (flip) begin
            pr     = ~dbv[b];
            dbv[b] = ~dbv[b];
        end
    endtask

    task automatic model_edge(input bit r, input bit bn, input bit bp, input bit ae);
        bit [2:0] s;
        bit pn, pp;
        int old_sel;
        if (r) begin
            rawq = {3'b000, 3'b000};
            histn.delete();
            histp.delete();
            dbv = 2'b00;
            m_sel = 0; m_chg = 0; m_mode = 0; since_entry = 0;
            return;
        end
        s = rawq[0];
        void'(rawq.pop_front());
        rawq.push_back({ae, bp, bn});
        db_step(0, s[0], pn);
        db_step(1, s[1], pp);
        old_sel = m_sel;
        if (m_mode == 0) begin
            if (pn && !pp)      m_sel = (m_sel + 1) % 4;
            else if (pp && !pn) m_sel = (m_sel + 3) % 4;
            if (s[2]) begin m_mode = 1; since_entry = 0; end
        end else begin
            if (!s[2]) begin
                m_mode = 0; since_entry = 0;
            end else begin
                since_entry++;
                if (since_entry % P == 0) m_sel = (m_sel + 1) % 4;
            end
        end
        m_chg = (m_sel != old_sel) ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: drive the inputs, advance the model, and compare all outputs 1 time unit later.
    task automatic tick(input bit r, input bit bn, input bit bp, input bit ae);
        rst = r; btn_next = bn; btn_prev = bp; auto_en = ae;
        @(posedge clk);
        model_edge(r, bn, bp, ae);
        #1;
        $display("t=%0t rst=%0b nx=%0b pv=%0b au=%0b -> sel=%0d chg=%0b mode=%0b (exp %0d %0d %0d)",
                 $time, r, bn, bp, ae, sel, sel_chg, mode, m_sel, m_chg, m_mode);
        chk("sel", 32'(sel), 32'(m_sel));
        chk("sel_chg", 32'(sel_chg), 32'(m_chg));
        chk("mode", 32'(mode), 32'(m_mode));
    endtask

    initial begin
        int lat;
        bit [6:0] bounce;
        bounce = 7'b0111011; // 1,1,0,1,1,1,0 applied LSB first

        // 1. Reset and idle.
        repeat (2) tick(1, 0, 0, 0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_mode", 32'(mode), 32'd0);
        repeat (20) tick(0, 0, 0, 0);
        chk("idle_sel", 32'(sel), 32'd0);

        // 2. The press latency is E+5, so the change shows on the 6th edge counted from E.
        lat = 0;
        while (sel !== 2'd1 && lat < 20) begin tick(0, 1, 0, 0); lat++; end
        chk("press_latency", 32'(lat), 32'(2 + D));
        repeat (4) tick(0, 1, 0, 0);
        repeat (8) tick(0, 0, 0, 0);
        repeat (4) begin
            repeat (8) tick(0, 1, 0, 0);
            repeat (8) tick(0, 0, 0, 0);
        end
        chk("wrap_next", 32'(sel), 32'd1);

        // 3. A bounce followed by a steady hold.
        for (int i = 0; i < 7; i++) tick(0, bounce[i], 0, 0);
        chk("bounce_nochange", 32'(sel), 32'd1);
        lat = 0;
        while (sel === 2'd1 && lat < 20) begin tick(0, 1, 0, 0); lat++; end
        chk("bounce_latency", 32'(lat), 32'(2 + D));
        repeat (8) tick(0, 0, 0, 0);

        // 4. Simultaneous presses, then prev alone.
        repeat (10) tick(0, 1, 1, 0);
        chk("both_nochange", 32'(sel), 32'd2);
        repeat (8) tick(0, 0, 0, 0);
        repeat (2) begin
            repeat (8) tick(0, 0, 1, 0);
            repeat (8) tick(0, 0, 0, 0);
        end
        chk("prev_to_zero", 32'(sel), 32'd0);
        repeat (8) tick(0, 0, 1, 0);
        repeat (8) tick(0, 0, 0, 0);
        chk("wrap_prev", 32'(sel), 32'd3);

        // 5. Auto-scan with ignored presses, then exit while a button is held.
        repeat (2) tick(0, 0, 0, 1);
        chk("auto_not_yet", 32'(mode), 32'd0);
        tick(0, 0, 0, 1);
        chk("auto_entry", 32'(mode), 32'd1);
        for (int i = 0; i < 40; i++) tick(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
        repeat (10) tick(0, 1, 0, 1);
        repeat (12) tick(0, 1, 0, 0);
        repeat (8) tick(0, 0, 0, 0);

        // 6a. A reset in mid-debounce, with the button still held.
        repeat (5) tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("rst_db_sel", 32'(sel), 32'd0);
        chk("rst_db_chg", 32'(sel_chg), 32'd0);
        lat = 0;
        while (sel === 2'd0 && lat < 20) begin tick(0, 1, 0, 0); lat++; end
        chk("rst_fresh_latency", 32'(lat), 32'(2 + D));
        repeat (8) tick(0, 0, 0, 0);

        // 6b. A reset in mid-AUTO, with pc at 5.
        lat = 0;
        while (mode !== 1'b1 && lat < 20) begin tick(0, 0, 0, 1); lat++; end
        chk("auto_reached", 32'(mode), 32'd1);
        repeat (5) tick(0, 0, 0, 1);
        tick(1, 0, 0, 1);
        chk("rst_auto_mode", 32'(mode), 32'd0);
        chk("rst_auto_sel", 32'(sel), 32'd0);
        repeat (14) tick(0, 0, 0, 1);
        repeat (6) tick(0, 0, 0, 0);

        // 7. Random segments of held input levels, with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            bit r, bn, bp, ae;
            int len;
            r   = ($urandom_range(0, 19) == 0);
            bn  = ($urandom_range(0, 1) == 1);
            bp  = ($urandom_range(0, 2) == 0);
            ae  = ($urandom_range(0, 3) == 0);
            len = r ? 1 : $urandom_range(1, 14);
            repeat (len) tick(r, bn, bp, ae);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
